// File: rtl/serial_adder_nbit.sv
// Bit-serial adder: Sum = A + B + Cin computed LSB first through one full-adder cell.
// Define SERIAL_ADDER_OVF_EN to add the registered signed Overflow output.
module serial_adder_nbit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             Overflow
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] psum_q, psum_d;
    logic [CW-1:0]    bitcnt_q, bitcnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] psum_shift;

    // The single full-adder cell, fed from the LSBs of the operand shift registers.
    assign s_bit      = a_q[0] ^ b_q[0] ^ carry_q;
    assign c_next     = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
    assign psum_shift = {s_bit, psum_q[WIDTH-1:1]};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        carry_d  = carry_q;
        psum_d   = psum_q;
        bitcnt_d = bitcnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d    = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d      = A;
                    b_d      = B;
                    carry_d  = Cin;
                    bitcnt_d = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                carry_d  = c_next;
                psum_d   = psum_shift;
                bitcnt_d = bitcnt_q + 1'b1;
                if (bitcnt_q == LAST_BIT) begin
                    bitcnt_d = '0;
                    sum_d    = psum_shift;
                    cout_d   = c_next;
`ifdef SERIAL_ADDER_OVF_EN
                    // On the last bit a_q[0]/b_q[0] are the captured operand MSBs.
                    ovf_d    = (a_q[0] == b_q[0]) && (s_bit != a_q[0]);
`endif
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            psum_q   <= '0;
            bitcnt_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            carry_q  <= carry_d;
            psum_q   <= psum_d;
            bitcnt_q <= bitcnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= ovf_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign Sum  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign Overflow = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_nbit.sv
// Directed and exhaustive bench for serial_adder_nbit (WIDTH=4); checks Overflow when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder_nbit;

    localparam int W = 4;
    localparam int LAT_LIMIT = 50;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    int tests_run;
    int tests_failed;

    // Expected entries are {overflow, cout, sum}.
    logic [W+1:0] exp_q[$];
    logic [W-1:0] last_sum;

    serial_adder_nbit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (a_in),
        .B     (b_in),
        .Cin   (cin),
        .busy  (busy),
        .done  (done),
        .Sum   (sum),
        .Cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .Overflow (ovf)
`endif
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        logic [W:0] full;
        logic       v;
        full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
        v    = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        return {v, full};
    endfunction

    task automatic compare_result(input string tag);
        logic [W+1:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_unexpected_done"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
            check({tag, "_cout"}, 32'(cout), 32'(e[W]));
`ifdef SERIAL_ADDER_OVF_EN
            check({tag, "_ovf"}, 32'(ovf), 32'(e[W+1]));
`endif
            last_sum = e[W-1:0];
        end
    endtask

    // Driver: one operation; with noisy=1, start and operands are scrambled while busy.
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c, input bit noisy);
        int lat;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        cin   = c;
        exp_q.push_back(model(a, b, c));
        @(negedge clk);
        lat = 0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && lat < LAT_LIMIT) begin
            if (noisy) begin
                start = 1'b1;
                a_in  = W'($urandom_range(0, (1 << W) - 1));
                b_in  = W'($urandom_range(0, (1 << W) - 1));
                cin   = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
            check({tag, "_sum_held"}, 32'(sum), 32'(last_sum));
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            check({tag, "_done_timeout"}, 32'(lat), 32'(W));
        end else begin
            check({tag, "_latency"}, 32'(lat), 32'(W));
            compare_result(tag);
        end
        @(negedge clk);
        check({tag, "_done_low"}, 32'(done), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int last_done;
        int n_done;
        tests_run    = 0;
        tests_failed = 0;
        last_sum     = '0;
        rst   = 1'b1;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;
        cin   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
        check("reset_ovf", 32'(ovf), 32'd0);
`endif

        // Basic operations and boundaries
        run_op("add_5_3", 4'd5, 4'd3, 1'b0, 1'b0);
        run_op("add_15_1", 4'd15, 4'd1, 1'b0, 1'b0);
        run_op("add_15_15_c", 4'd15, 4'd15, 1'b1, 1'b0);

        // start and operands toggled during the operation must be ignored
        run_op("ignore_start", 4'd2, 4'd2, 1'b0, 1'b1);
        check("ignore_start_q_empty", 32'(exp_q.size()), 32'd0);

        // Back-to-back with start held high
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd1;
        b_in  = 4'd1;
        cin   = 1'b0;
        exp_q.push_back(model(4'd1, 4'd1, 1'b0));
        last_done = -100;
        n_done    = 0;
        for (int i = 1; i <= 18; i++) begin
            @(negedge clk);
            if (done) begin
                if (n_done > 0) check("b2b_gap", 32'(i - last_done), 32'd6);
                else check("b2b_first", 32'(i), 32'(W + 1));
                compare_result("b2b");
                last_done = i;
                n_done++;
            end
            if (i < 18 && !busy) exp_q.push_back(model(4'd1, 4'd1, 1'b0));
        end
        start = 1'b0;
        check("b2b_count", 32'(n_done), 32'd3);
        check("b2b_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset during RUN bit 2 aborts the operation
        @(negedge clk);
        start = 1'b1;
        a_in  = 4'd9;
        b_in  = 4'd4;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        last_sum = '0;
        repeat (W + 2) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        run_op("after_abort", 4'd6, 4'd7, 1'b0, 1'b0);

        // Exhaustive sweep
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                for (int c = 0; c < 2; c++) begin
                    run_op("sweep", W'(a), W'(b), 1'(c), 1'b0);
                end
            end
        end
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
